mult32x32_ctrl: RTL and testbench

//  Control FSM for the 32x32 multiplier. Drives the arithmetic unit (mult32x32_arith) from a start/busy/done handshake.

---
 rtl/mult32x32_ctrl.sv | 125 ++++++++++++
 tb/tb_mult32x32_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult32x32_ctrl.sv
// Control FSM for the 32x32 multiplier: sequences up to four 16x16 partial
// products into the arithmetic unit and reports completion with a done pulse.
module mult32x32_ctrl #(
  parameter bit SKIP_ZERO = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             busy,
  output logic             done,
  output logic             a_sel,
  output logic             b_sel,
  output logic [1:0]       shift_sel,
  output logic             upd_prod,
  output logic             clr_prod,
  output logic [CNT_W-1:0] mult_count
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       stepEn;
  logic [2:0]       nextHit;

  // Returns {found, index} of the lowest enabled step at or above 'from'.
  function automatic logic [2:0] nextStep(input logic [3:0] en, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= from) && en[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Step i pairs a-half ~i[1] with b-half ~i[0]; enables follow the live operands.
  always_comb begin
    if (SKIP_ZERO) begin
      stepEn = {(|a[31:16]) & (|b[31:16]),
                (|a[31:16]) & (|b[15:0]),
                (|a[15:0])  & (|b[31:16]),
                (|a[15:0])  & (|b[15:0])};
    end else begin
      stepEn = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    count_d = count_q;
    nextHit = 3'b000;
    case (state_q)
      IDLE: begin
        if (start) begin
          nextHit = nextStep(stepEn, 3'd0);
          state_d = nextHit[2] ? STEP : DONE;
          step_d  = nextHit[1:0];
        end
      end
      STEP: begin
        nextHit = nextStep(stepEn, {1'b0, step_q} + 3'd1);
        state_d = nextHit[2] ? STEP : DONE;
        step_d  = nextHit[2] ? nextHit[1:0] : step_q;
      end
      DONE: begin
        state_d = IDLE;
        count_d = count_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, even the Mealy clear.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    a_sel      = 1'b0;
    b_sel      = 1'b0;
    shift_sel  = 2'b00;
    upd_prod   = 1'b0;
    clr_prod   = 1'b0;
    mult_count = '0;
    if (!reset) begin
      mult_count = count_q;
      case (state_q)
        IDLE: clr_prod = start;
        STEP: begin
          busy     = 1'b1;
          upd_prod = 1'b1;
          a_sel    = ~step_q[1];
          b_sel    = ~step_q[0];
          case (step_q)
            2'd0:    shift_sel = 2'b00;
            2'd3:    shift_sel = 2'b10;
            default: shift_sel = 2'b01;
          endcase
        end
        DONE: begin
          busy      = 1'b1;
          done      = 1'b1;
          shift_sel = 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Self-checking bench for mult32x32_ctrl: two instances (full sequence with a
// narrow counter, zero-skipping) each driving a behavioural product accumulator.
module tb_mult32x32_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start0, start1;
  logic [31:0] a, b;

  logic        busy0, done0, asel0, bsel0, upd0, clr0;
  logic [1:0]  sh0;
  logic [2:0]  cnt0;
  logic        busy1, done1, asel1, bsel1, upd1, clr1;
  logic [1:0]  sh1;
  logic [15:0] cnt1;

  mult32x32_ctrl #(.SKIP_ZERO(1'b0), .CNT_W(3)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a), .b(b),
    .busy(busy0), .done(done0), .a_sel(asel0), .b_sel(bsel0), .shift_sel(sh0),
    .upd_prod(upd0), .clr_prod(clr0), .mult_count(cnt0));

  mult32x32_ctrl #(.SKIP_ZERO(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a), .b(b),
    .busy(busy1), .done(done1), .a_sel(asel1), .b_sel(bsel1), .shift_sel(sh1),
    .upd_prod(upd1), .clr_prod(clr1), .mult_count(cnt1));

  // Behavioural stand-in for the arithmetic unit's product register.
  function automatic logic [63:0] pp(input logic [31:0] av, input logic [31:0] bv,
                                     input logic as, input logic bs, input logic [1:0] sh);
    logic [15:0] ah, bh;
    logic [63:0] m;
    ah = as ? av[15:0] : av[31:16];
    bh = bs ? bv[15:0] : bv[31:16];
    m  = 64'(ah) * 64'(bh);
    case (sh)
      2'b00:   return m;
      2'b01:   return m << 16;
      2'b10:   return m << 32;
      default: return 64'd0;
    endcase
  endfunction

  logic [63:0] prod0, prod1;
  always_ff @(posedge clk) begin
    if (reset || clr0) prod0 <= 64'd0;
    else if (upd0)     prod0 <= prod0 + pp(a, b, asel0, bsel0, sh0);
    if (reset || clr1) prod1 <= 64'd0;
    else if (upd1)     prod1 <= prod1 + pp(a, b, asel1, bsel1, sh1);
  end

  int          curDut = 0;
  logic        selDone, selUpd;
  logic [63:0] selProd;
  assign selDone = (curDut != 0) ? done1 : done0;
  assign selUpd  = (curDut != 0) ? upd1  : upd0;
  assign selProd = (curDut != 0) ? prod1 : prod0;

  int vecCount  = 0;
  int missCount = 0;
  int expCnt0   = 0;
  int expCnt1   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          steps;
  } vec_t;

  typedef struct {
    int          lat;
    logic [63:0] prod;
    int          steps;
  } exp_t;

  exp_t sbq[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulses start on the chosen instance for one cycle and queues the expected result.
  task automatic applyStimulus(input int d, input logic [31:0] av, input logic [31:0] bv,
                               input int steps);
    exp_t e;
    @(negedge clk);
    curDut = d;
    a = av;
    b = bv;
    if (d != 0) start1 = 1'b1; else start0 = 1'b1;
    e.lat   = steps + 1;
    e.prod  = {32'd0, av} * {32'd0, bv};
    e.steps = steps;
    sbq.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Entered in cycle 1 of an operation; waits (bounded) for done and scores it.
  task automatic waitResult(input string tag);
    int   lat, upds;
    exp_t e;
    lat  = 1;
    upds = 0;
    while (!selDone && lat <= 10) begin
      if (selUpd) upds++;
      @(negedge clk);
      lat++;
    end
    e = sbq.pop_front();
    checkOutput({tag, " latency"}, 64'(lat), 64'(e.lat));
    checkOutput({tag, " product"}, selProd, e.prod);
    checkOutput({tag, " steps"}, 64'(upds), 64'(e.steps));
    @(negedge clk);
    if (curDut != 0) begin
      expCnt1++;
      checkOutput({tag, " count"}, 64'(cnt1), 64'(expCnt1 & 16'hFFFF));
    end else begin
      expCnt0++;
      checkOutput({tag, " count"}, 64'(cnt0), 64'(expCnt0 & 7));
    end
  endtask

  vec_t vecs[10];
  logic expA[4];
  logic expB[4];
  logic [1:0] expS[4];

  initial begin
    int   lat;
    logic sawDone;
    exp_t e;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4};
    vecs[1] = '{32'h00010000, 32'h00000003, 1};
    vecs[2] = '{32'h00000000, 32'h12345678, 0};
    vecs[3] = '{32'h00001234, 32'h00005678, 1};
    vecs[4] = '{32'h12340000, 32'h56780000, 1};
    vecs[5] = '{32'h0000FFFF, 32'hFFFF0000, 1};
    vecs[6] = '{32'h12345678, 32'h0000ABCD, 2};
    vecs[7] = '{32'h00000001, 32'h80000001, 2};
    vecs[8] = '{32'hFFFF0001, 32'h00010000, 2};
    vecs[9] = '{32'h12345678, 32'h9ABCDEF0, 4};
    expA = '{1'b1, 1'b1, 1'b0, 1'b0};
    expB = '{1'b1, 1'b0, 1'b1, 1'b0};
    expS = '{2'b00, 2'b01, 2'b01, 2'b10};

    // Reset held with start high: every output stays low.
    reset = 1'b1; start0 = 1'b1; start1 = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'({busy0, busy1}), 64'd0);
    checkOutput("reset clr", 64'({clr0, clr1}), 64'd0);
    checkOutput("reset count", 64'({cnt0, cnt1}), 64'd0);
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    checkOutput("post-reset busy", 64'({busy0, busy1, done0, done1}), 64'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, vecs[i].a, vecs[i].b, 4);
      waitResult($sformatf("full v%0d", i));
      applyStimulus(1, vecs[i].a, vecs[i].b, vecs[i].steps);
      waitResult($sformatf("skip v%0d", i));
    end

    // Full sequence in table order, with ignored start pulses at cycles 2 and 5
    // and a fresh start at cycle 6.
    curDut = 0;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        checkOutput($sformatf("seq c%0d ctl", c), 64'({busy0, done0, upd0}), 64'b101);
        checkOutput($sformatf("seq c%0d sel", c), 64'({asel0, bsel0, sh0}),
                    64'({expA[c-1], expB[c-1], expS[c-1]}));
      end else if (c == 5) begin
        checkOutput("seq c5 ctl", 64'({busy0, done0, upd0, sh0}), 64'b11011);
        checkOutput("seq c5 product", prod0, 64'hFFFFFFFE_00000001);
      end else begin
        expCnt0++;
        checkOutput("seq c6 busy", 64'({busy0, done0}), 64'd0);
        checkOutput("seq c6 count", 64'(cnt0), 64'(expCnt0 & 7));
      end
      start0 = (c == 2 || c == 5 || c == 6);
    end
    e.lat = 5; e.prod = 64'hFFFFFFFE_00000001; e.steps = 4;
    sbq.push_back(e);
    @(negedge clk);
    checkOutput("restart busy", 64'(busy0), 64'd1);
    start0 = 1'b0;
    waitResult("restart");

    // Reset in cycle 3 aborts the operation without a done pulse.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; start0 = 1'b1;
    #1;
    checkOutput("abort during reset", 64'({busy0, upd0, clr0, cnt0}), 64'd0);
    @(negedge clk);
    reset = 1'b0; start0 = 1'b0;
    expCnt0 = 0;
    checkOutput("abort c4 state", 64'({busy0, done0}), 64'd0);
    checkOutput("abort c4 product", prod0, 64'd0);
    checkOutput("abort c4 count", 64'(cnt0), 64'd0);
    sawDone = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sawDone |= done0;
    end
    checkOutput("abort no done", 64'(sawDone), 64'd0);

    // Start held high: back-to-back operations until the 3-bit counter wraps.
    @(negedge clk);
    a = 32'hCAFEBABE; b = 32'h0BADF00D; start0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!done0 && lat < 12);
      checkOutput($sformatf("wrap op%0d latency", k), 64'(lat), 64'd5);
      checkOutput($sformatf("wrap op%0d product", k), prod0, 64'hCAFEBABE * 64'h0BADF00D);
      @(negedge clk);
      checkOutput($sformatf("wrap op%0d count", k), 64'(cnt0), 64'((k + 1) & 7));
      if (k == 7) start0 = 1'b0;
    end
    @(negedge clk);
    checkOutput("wrap idle", 64'(busy0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
